uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `UART_tx` transmitter between two byte-stream requesters, for example the periodic telemetry packet source and a fault/diagnostic message source. Arbitration is round-robin at packet granularity: once a requester wins, it owns the UART until the UART finishes its `last` byte. A per-packet inter-byte watchdog releases a requester that stalls mid-packet. The block sits between the requesters and the `trmt`/`tx_data`/`tx_done` ports of `UART_tx`.

## Interface

**Parameters**
- `TIMEOUT`, default 1023: cycles an owner may idle between bytes of a packet before the lock is dropped. Legal range is ≥ 1.

**Ports** (clock and reset first)
- `clk`  in  1  system clock. This block has one clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 holds a valid byte on `data0`. Held until `ack0`.
- `data0`  in  8  byte from requester 0.
- `last0`  in  1  `data0` is the final byte of its packet.
- `ack0`  out  1  one-cycle pulse: byte from requester 0 accepted.
- `req1`, `data1`, `last1`, `ack1`  same as requester 0, for requester 1.
- `tx_data`  out  8  byte to `UART_tx`. Registered.
- `trmt`  out  1  one-cycle start pulse to `UART_tx`. Registered.
- `tx_done`  in  1  from `UART_tx`. Only its rising edge is used, so a pulse or a level is accepted.
- `grant`  out  2  one-hot current owner; `2'b00` when no packet is locked.
- `timeout_err`  out  1  one-cycle pulse when a lock is dropped by the watchdog.

## Operation

**State machine:** `IDLE`, `WAIT_DONE`, `WAIT_NEXT`.

- **`IDLE`** (no owner)
  - If any `req` is high, select a winner:
    - Only one `req` high: that requester wins.
    - Both high: the requester indicated by the round-robin pointer `rr` wins. `rr` resets to 0.
  - On a selection:
    - Capture `dataX` and `lastX`.
    - Next cycle: `trmt=1`, `tx_data=dataX`, `ackX=1`, `grant` = winner one-hot.
    - Go to `WAIT_DONE`.
- **`WAIT_DONE`**
  - Wait for a `tx_done` rising edge: `tx_done` high while the registered `tx_done_q` is low.
  - On the edge, if the captured `last` is 1:
    - Set `grant=00`.
    - Set `rr` = the other requester.
    - Go to `IDLE`.
  - On the edge, if `last` is 0:
    - Go to `WAIT_NEXT`, keeping `grant`.
    - Clear the watchdog counter.
- **`WAIT_NEXT`** (owner locked)
  - Only the owner's `req` is examined; the other requester is ignored.
  - If the owner's `req` is high: send exactly as in `IDLE`, then go to `WAIT_DONE`.
  - Otherwise the counter increments. When it equals `TIMEOUT`:
    - Pulse `timeout_err` (next cycle).
    - Set `grant=00`.
    - Set `rr` = the other requester.
    - Go to `IDLE`.
  - If the owner's `req` is high on the same cycle the counter equals `TIMEOUT`, the byte is sent and no timeout is raised.
- **Counter:** unsigned, width `$clog2(TIMEOUT+1)`. It never wraps because it is cleared on every entry to `WAIT_NEXT`.
- **Requester contract:**
  - A requester may deassert `req` without receiving `ack`; this is legal and nothing is consumed.
  - `last` of a non-owner has no effect.
  - A single-byte packet (`last` on the first byte) releases the lock after its `tx_done`.
- **Reset:** `rst` high on any cycle, including mid-frame, forces:
  - Next cycle: state `IDLE`, `rr=0`, counter 0, `tx_done_q=0`.
  - All outputs 0: `trmt`, `tx_data=8'h00`, `ack0`, `ack1`, `grant=00`, `timeout_err`.
  - The UART frame in flight is abandoned; its `tx_done` is ignored because the block is in `IDLE`.

## Timing

- **Selection latency:** a `req` sampled at cycle N in `IDLE` (or the owner's `req` in `WAIT_NEXT`) produces `trmt`/`ack` at N+1.
- **Requester hold:** requesters keep `data`/`last` stable through the `ack` cycle.
- **Byte-to-byte:** a `tx_done` rising edge at cycle M gives `WAIT_NEXT`/`IDLE` at M+1, and the earliest next `trmt` at M+2.
- **Duplicate consumption:** a byte still presented during its own `ack` cycle is not consumed twice, because the block is then in `WAIT_DONE`.
- **Watchdog:** `timeout_err` asserts exactly `TIMEOUT+1` cycles after the `WAIT_NEXT` entry cycle, provided the owner's `req` stays low.
- **Output timing:** `trmt`, `ack0`, `ack1` and `timeout_err` are never high for two consecutive cycles.

## Test plan

1. **Reset.** Hold `rst` for 2 cycles with `req0=1`. Required: `trmt=0`, `ack0=0`, `grant=00`, `tx_data=00`, `timeout_err=0` during reset. After release, the first `trmt` carries `data0`.
2. **Two-byte packet.** `req0` sends 0xAA (`last0=0`) then 0x55 (`last0=1`); the UART model raises `tx_done` 10 cycles after each `trmt`. Required:
   - `trmt`+`ack0` with 0xAA one cycle after `req0`.
   - Second `trmt` with 0x55 two cycles after the `tx_done` rise.
   - `grant=01` throughout; `grant=00` one cycle after the second `tx_done` rise.
3. **Round-robin.** Out of reset, `req0` and `req1` both assert continuously with single-byte packets 0x11 and 0x22. Required: `tx_data` sequence 0x11, 0x22, 0x11, 0x22.
4. **Packet lock.** `req0` sends a 3-byte packet 0x01, 0x02, 0x03 while `req1` holds 0x99. Required: `ack1` stays 0 until after 0x03's `tx_done`; the next `trmt` carries 0x99.
5. **Timeout.** `TIMEOUT=16`; `req0` sends 0x01 (`last0=0`) and then drops `req`. Required: `timeout_err` pulses once, 17 cycles after `WAIT_NEXT` entry; `grant=00`; a pending `req1` 0x77 is sent next. Variant: `req0` reasserts on the counter==16 cycle. Required: byte sent, `timeout_err` stays 0.
6. **Reset mid-frame.** Assert `rst` in `WAIT_DONE`, then deliver `tx_done`. Required: all outputs 0, no `trmt`/`ack` generated by that stale `tx_done`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART_tx between two byte-stream requesters.
// An inter-byte watchdog drops the lock if the owner stalls mid-packet.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       last0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       last1,
    output logic       ack1,
    output logic [7:0] tx_data,
    output logic       trmt,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, WAIT_NEXT} state_t;

    state_t        state;
    logic          rr;
    logic          owner;
    logic          last_q;
    logic          tx_done_q;
    logic [CW-1:0] cnt;

    logic          pick_valid;
    logic          pick;
    logic [7:0]    pick_data;
    logic          pick_last;
    logic          done_rise;

    // In IDLE either requester may win; in WAIT_NEXT only the locked owner is looked at.
    always_comb begin
        pick_valid = 1'b0;
        pick       = 1'b0;
        case (state)
            IDLE: begin
                pick_valid = req0 | req1;
                pick       = (req0 && req1) ? rr : req1;
            end
            WAIT_NEXT: begin
                pick_valid = owner ? req1 : req0;
                pick       = owner;
            end
            default: begin
                pick_valid = 1'b0;
                pick       = 1'b0;
            end
        endcase
        pick_data = pick ? data1 : data0;
        pick_last = pick ? last1 : last0;
        done_rise = tx_done & ~tx_done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            owner       <= 1'b0;
            last_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            cnt         <= '0;
            trmt        <= 1'b0;
            tx_data     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            grant       <= '0;
            timeout_err <= 1'b0;
        end else begin
            trmt        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;
            tx_done_q   <= tx_done;
            // A pending owner byte takes priority over the watchdog on the same cycle.
            if (pick_valid) begin
                trmt    <= 1'b1;
                tx_data <= pick_data;
                ack0    <= ~pick;
                ack1    <= pick;
                grant   <= pick ? 2'b10 : 2'b01;
                owner   <= pick;
                last_q  <= pick_last;
                state   <= WAIT_DONE;
            end else begin
                case (state)
                    WAIT_DONE: begin
                        if (done_rise) begin
                            if (last_q) begin
                                grant <= '0;
                                rr    <= ~owner;
                                state <= IDLE;
                            end else begin
                                cnt   <= '0;
                                state <= WAIT_NEXT;
                            end
                        end
                    end
                    WAIT_NEXT: begin
                        if (cnt == TMAX) begin
                            timeout_err <= 1'b1;
                            grant       <= '0;
                            rr          <= ~owner;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic checked
// against per-requester byte queues and the packet-lock / round-robin rules.
module tb_uart_tx_arbiter;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ack0, ack1, trmt, timeout_err, tx_done;
    logic [7:0] tx_data;
    logic [1:0] grant;

    logic       uart_en = 1'b0, uart_done = 1'b0, man_done = 1'b0;
    logic [3:0] cd = '0;
    logic       s_req0 = 1'b0, s_req1 = 1'b0;
    bit         done0 = 0, done1 = 0;
    logic [8:0] q_drv0[$], q_drv1[$], sb0[$], sb1[$];

    int n_pass = 0;
    int n_total = 0;

    assign tx_done = uart_done | man_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
        .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .grant(grant), .timeout_err(timeout_err)
    );

    // UART model: one-cycle tx_done pulse about 10 cycles after each trmt.
    always @(posedge clk) begin
        uart_done <= 1'b0;
        if (!uart_en) cd <= '0;
        else if (trmt) cd <= 4'd10;
        else if (cd != 4'd0) begin
            cd <= cd - 4'd1;
            if (cd == 4'd1) uart_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        s_req0 <= req0;
        s_req1 <= req1;
    end

    task automatic do_reset(input logic en);
        @(negedge clk);
        uart_en = 1'b0; rst = 1'b1; man_done = 1'b0;
        req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0; data0 = '0; data1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; uart_en = en;
    endtask

    task automatic wait_tx_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        uart_en = 1'b0; rst = 1'b1; req0 = 1'b1; data0 = 8'hC3; last0 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_total++;
            if ({trmt, ack0, ack1, timeout_err, grant, tx_data} !== 14'd0)
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, {trmt, ack0, ack1, timeout_err, grant, tx_data});
            else n_pass++;
        end
        rst = 1'b0; uart_en = 1'b1;
        @(negedge clk);
        n_total++;
        if ({trmt, ack0, ack1, grant} !== 5'b11001)
            $display("FAIL reset_first_send: got %b expected 11001", {trmt, ack0, ack1, grant});
        else n_pass++;
        n_total++;
        if (tx_data !== 8'hC3) $display("FAIL reset_first_data: got %h expected c3", tx_data);
        else n_pass++;
        req0 = 1'b0;
    endtask

    task automatic test_two_byte();
        bit ok;
        do_reset(1'b1);
        req0 = 1'b1; data0 = 8'hAA; last0 = 1'b0;
        @(negedge clk);
        n_total++;
        if ({trmt, ack0, ack1, grant, tx_data} !== {5'b11001, 8'hAA})
            $display("FAIL two_byte_first: got %h expected %h", {trmt, ack0, ack1, grant, tx_data}, {5'b11001, 8'hAA});
        else n_pass++;
        data0 = 8'h55; last0 = 1'b1;
        wait_tx_done(ok);
        n_total++;
        if (!ok || grant !== 2'b01) $display("FAIL two_byte_done1: ok %0d grant %b expected 01", ok, grant);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (trmt !== 1'b0 || grant !== 2'b01) $display("FAIL two_byte_gap: trmt %b grant %b expected 0/01", trmt, grant);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({trmt, ack0, grant, tx_data} !== {4'b1101, 8'h55})
            $display("FAIL two_byte_second: got %h expected %h", {trmt, ack0, grant, tx_data}, {4'b1101, 8'h55});
        else n_pass++;
        req0 = 1'b0;
        wait_tx_done(ok);
        n_total++;
        if (!ok || grant !== 2'b01) $display("FAIL two_byte_done2: ok %0d grant %b expected 01", ok, grant);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (grant !== 2'b00) $display("FAIL two_byte_release: grant %b expected 00", grant);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_seq [4];
        int k;
        exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
        k = 0;
        do_reset(1'b1);
        req0 = 1'b1; data0 = 8'h11; last0 = 1'b1;
        req1 = 1'b1; data1 = 8'h22; last1 = 1'b1;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clk);
            if (trmt) begin
                n_total++;
                if (tx_data !== exp_seq[k] || ack1 !== 1'(k % 2) || ack0 !== 1'((k + 1) % 2))
                    $display("FAIL rr_byte%0d: data %h ack %b%b expected %h", k, tx_data, ack1, ack0, exp_seq[k]);
                else n_pass++;
                k++;
            end
        end
        n_total++;
        if (k != 4) $display("FAIL rr_count: got %0d expected 4", k);
        else n_pass++;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_packet_lock();
        logic [7:0] pkt [3];
        bit early, got;
        int done_at, trmt_at;
        pkt = '{8'h01, 8'h02, 8'h03};
        early = 0;
        do_reset(1'b1);
        req1 = 1'b1; data1 = 8'h99; last1 = 1'b1;
        for (int b = 0; b < 3; b++) begin
            req0 = 1'b1; data0 = pkt[b]; last0 = (b == 2);
            got = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (ack1) early = 1;
                if (trmt) begin got = 1; break; end
            end
            n_total++;
            if (!got || tx_data !== pkt[b] || ack0 !== 1'b1)
                $display("FAIL lock_byte%0d: got %0d data %h ack0 %b expected %h", b, got, tx_data, ack0, pkt[b]);
            else n_pass++;
        end
        req0 = 1'b0;
        done_at = -1; trmt_at = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_done && done_at < 0) done_at = i;
            if (trmt) begin trmt_at = i; break; end
            if (ack1) early = 1;
        end
        n_total++;
        if (early) $display("FAIL lock_ack1_early: got 1 expected 0");
        else n_pass++;
        n_total++;
        if (trmt_at < 0 || tx_data !== 8'h99 || ack1 !== 1'b1 || trmt_at - done_at != 2)
            $display("FAIL lock_handover: at %0d (done %0d) data %h ack1 %b expected 99 two cycles after done", trmt_at, done_at, tx_data, ack1);
        else n_pass++;
        req1 = 1'b0;
    endtask

    task automatic test_timeout(input bit rescue);
        bit ok;
        int tcount, tm_at, tr_at;
        logic [1:0] grant_tm;
        logic [7:0] tr_data;
        logic [1:0] tr_ack;
        tcount = 0; tm_at = -1; tr_at = -1; grant_tm = 2'b11; tr_data = '0; tr_ack = '0;
        do_reset(1'b1);
        req0 = 1'b1; data0 = 8'h01; last0 = 1'b0;
        @(negedge clk);
        n_total++;
        if ({trmt, ack0, tx_data} !== {2'b11, 8'h01}) $display("FAIL tmo_first(%0d): got %h expected 301", rescue, {trmt, ack0, tx_data});
        else n_pass++;
        req0 = 1'b0;
        if (!rescue) begin req1 = 1'b1; data1 = 8'h77; last1 = 1'b1; end
        wait_tx_done(ok);
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                tcount++;
                if (tm_at < 0) begin tm_at = i; grant_tm = grant; end
            end
            if (trmt && tr_at < 0) begin
                tr_at = i; tr_data = tx_data; tr_ack = {ack1, ack0};
                req0 = 1'b0; req1 = 1'b0;
            end
            if (rescue && i == int'(TMO) + 1) begin req0 = 1'b1; data0 = 8'h02; last0 = 1'b1; end
        end
        if (!rescue) begin
            n_total++;
            if (!ok || tm_at != int'(TMO) + 2 || tcount != 1)
                $display("FAIL tmo_pulse: at %0d count %0d expected at %0d count 1", tm_at, tcount, TMO + 2);
            else n_pass++;
            n_total++;
            if (grant_tm !== 2'b00) $display("FAIL tmo_grant: got %b expected 00", grant_tm);
            else n_pass++;
            n_total++;
            if (tr_at != int'(TMO) + 3 || tr_data !== 8'h77 || tr_ack !== 2'b10)
                $display("FAIL tmo_next: at %0d data %h ack %b expected at %0d data 77 ack 10", tr_at, tr_data, tr_ack, TMO + 3);
            else n_pass++;
        end else begin
            n_total++;
            if (!ok || tcount != 0) $display("FAIL rescue_no_tmo: count %0d expected 0", tcount);
            else n_pass++;
            n_total++;
            if (tr_at != int'(TMO) + 2 || tr_data !== 8'h02 || tr_ack !== 2'b01)
                $display("FAIL rescue_send: at %0d data %h ack %b expected at %0d data 02 ack 01", tr_at, tr_data, tr_ack, TMO + 2);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        bit clean;
        clean = 1;
        do_reset(1'b0);
        req0 = 1'b1; data0 = 8'h5A; last0 = 1'b1;
        @(negedge clk);
        n_total++;
        if ({trmt, ack0, tx_data} !== {2'b11, 8'h5A}) $display("FAIL mid_send: got %h expected 35a", {trmt, ack0, tx_data});
        else n_pass++;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({trmt, ack0, ack1, timeout_err, grant, tx_data} !== 14'd0)
            $display("FAIL mid_reset_outputs: got %h expected 0", {trmt, ack0, ack1, timeout_err, grant, tx_data});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({trmt, ack0, ack1, timeout_err, grant, tx_data} !== 14'd0) clean = 0;
        end
        n_total++;
        if (!clean) $display("FAIL mid_stale_done: got activity expected none");
        else n_pass++;
    endtask

    task automatic drive(input int id);
        logic [8:0] it;
        bit first, got;
        int gap;
        first = 1;
        while ((id == 0 ? q_drv0.size() : q_drv1.size()) != 0) begin
            if (id == 0) it = q_drv0.pop_front(); else it = q_drv1.pop_front();
            gap = first ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 5));
            repeat (gap) @(negedge clk);
            if (id == 0) begin req0 = 1'b1; data0 = it[7:0]; last0 = it[8]; end
            else         begin req1 = 1'b1; data1 = it[7:0]; last1 = it[8]; end
            got = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if ((id == 0) ? ack0 : ack1) begin got = 1; break; end
            end
            if (id == 0) req0 = 1'b0; else req1 = 1'b0;
            if (!got) begin
                n_total++;
                $display("FAIL rand_ack_wait req%0d: got no ack expected ack within 400 cycles", id);
                break;
            end
            first = it[8];
        end
        if (id == 0) done0 = 1; else done1 = 1;
    endtask

    task automatic test_random();
        logic [8:0] it;
        int len, tail, prev_src, exp_rr, tmo_seen, src;
        bit prev_last;
        tail = 0; prev_src = 0; exp_rr = 0; tmo_seen = 0; prev_last = 1;
        do_reset(1'b1);
        done0 = 0; done1 = 0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 6; p++) begin
                len = int'($urandom_range(1, 3));
                for (int b = 0; b < len; b++) begin
                    it = {(b == len - 1), 8'($urandom_range(0, 255))};
                    if (r == 0) begin q_drv0.push_back(it); sb0.push_back(it); end
                    else        begin q_drv1.push_back(it); sb1.push_back(it); end
                end
            end
        end
        fork
            drive(0);
            drive(1);
            begin
                for (int c = 0; c < 4000; c++) begin
                    @(negedge clk);
                    if (timeout_err) tmo_seen++;
                    if (trmt) begin
                        src = ack1 ? 1 : 0;
                        n_total++;
                        if (!(ack0 ^ ack1) || grant !== {ack1, ack0})
                            $display("FAIL rand_ack_grant: ack %b%b grant %b expected one-hot match", ack1, ack0, grant);
                        else n_pass++;
                        it = 9'h100;
                        n_total++;
                        if ((src == 0 ? sb0.size() : sb1.size()) == 0)
                            $display("FAIL rand_extra_byte req%0d: got %h expected none", src, tx_data);
                        else begin
                            if (src == 0) it = sb0.pop_front(); else it = sb1.pop_front();
                            if (tx_data !== it[7:0]) $display("FAIL rand_data req%0d: got %h expected %h", src, tx_data, it[7:0]);
                            else n_pass++;
                        end
                        if (!prev_last) begin
                            n_total++;
                            if (src != prev_src) $display("FAIL rand_lock: got req%0d expected req%0d", src, prev_src);
                            else n_pass++;
                        end else if (s_req0 && s_req1) begin
                            n_total++;
                            if (src != exp_rr) $display("FAIL rand_rr: got req%0d expected req%0d", src, exp_rr);
                            else n_pass++;
                        end
                        prev_last = it[8];
                        prev_src = src;
                        if (prev_last) exp_rr = 1 - src;
                    end
                    if (done0 && done1) begin
                        tail++;
                        if (tail > 3) break;
                    end
                end
            end
        join
        n_total++;
        if (sb0.size() != 0 || sb1.size() != 0)
            $display("FAIL rand_leftover: got %0d/%0d bytes unsent expected 0/0", sb0.size(), sb1.size());
        else n_pass++;
        n_total++;
        if (tmo_seen != 0) $display("FAIL rand_timeout: got %0d pulses expected 0", tmo_seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_two_byte();
        test_round_robin();
        test_packet_lock();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
